// File: rtl/jtcps2_pkg.sv
// Shared definitions for the CPS2 key-load sequencer: state encoding and key size.
package jtcps2_pkg;

  // Total key bytes held by the key-load register file.
  localparam int KEY_BYTES = 20;

  // Sequencer states, in the order a normal load walks through them.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_EMIT_LO = 3'd3,
    ST_GAP_LO  = 3'd4,
    ST_EMIT_HI = 3'd5,
    ST_GAP_HI  = 3'd6,
    ST_DONE    = 3'd7
  } keyseq_state_t;

endpackage

// File: rtl/jtcps2_keyseq_emit.sv
// Byte strobe generator: passes the one-cycle write pulse through and times the
// GAP low cycles that follow it, flagging the last gap cycle to the sequencer.
module jtcps2_keyseq_emit #(
  parameter int GAP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fire,      // sequencer is in an EMIT state this cycle
  input  logic gap_act,   // sequencer is in a GAP state this cycle
  output logic kl_we,
  output logic gap_last
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  logic [3:0] gap_cnt;

  // Load the gap length on the strobe, then count down to zero; never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (fire) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      gap_cnt <= GAP_LOAD;
    end else if (gap_act && (gap_cnt != 4'd0)) begin
      gap_cnt <= gap_cnt - 4'd1;
    end
  end

  assign kl_we    = fire;
  assign gap_last = gap_act && (gap_cnt == 4'd0);

endmodule

// File: rtl/jtcps2_keyseq.sv
// CPS2 key-load sequencer: reads WORDS 16-bit words from SDRAM starting at
// KEY_BASE and writes them byte by byte (low byte first) into the key-load
// register file, with GAP idle cycles after every byte strobe.
// Optional feature: define JTCPS2_KEYSEQ_SUM_EN to enable the 12-bit running
// byte checksum on 'sum'; otherwise 'sum' is tied to zero.
module jtcps2_keyseq
  import jtcps2_pkg::*;
#(
  parameter logic [21:0] KEY_BASE = 22'h0,
  parameter int          GAP      = 4,
  parameter int          WORDS    = KEY_BYTES / 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [21:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ok,
  input  logic [15:0] mem_data,
  output logic        kl_clr,
  output logic [7:0]  kl_din,
  output logic        kl_we,
  output logic [11:0] sum
);

  localparam int               IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  keyseq_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      data_q;
  logic             fire, gap_act, gap_last;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides everything while a sequence is running.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE,
      ST_DONE:    if (start && !abort) state_d = ST_CLR;
      ST_CLR:     state_d = ST_FETCH;
      ST_FETCH:   if (mem_ok) state_d = ST_EMIT_LO;
      ST_EMIT_LO: state_d = ST_GAP_LO;
      ST_GAP_LO:  if (gap_last) state_d = ST_EMIT_HI;
      ST_EMIT_HI: state_d = ST_GAP_HI;
      ST_GAP_HI:  if (gap_last) state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_FETCH;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && busy) state_d = ST_IDLE;
  end

  // Word index: cleared at the start of a load, advanced after each high byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (state_q == ST_CLR) begin
      idx_q <= '0;
    end else if ((state_q == ST_GAP_HI) && gap_last && (idx_q != IDX_LAST) && !abort) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Capture the memory word on the acknowledge cycle of a FETCH only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if ((state_q == ST_FETCH) && mem_ok) begin
      data_q <= mem_data;
    end
  end

  assign fire    = (state_q == ST_EMIT_LO) || (state_q == ST_EMIT_HI);
  assign gap_act = (state_q == ST_GAP_LO)  || (state_q == ST_GAP_HI);

  jtcps2_keyseq_emit #(
    .GAP (GAP)
  ) u_emit (
    .clk      (clk),
    .rst      (rst),
    .fire     (fire),
    .gap_act  (gap_act),
    .kl_we    (kl_we),
    .gap_last (gap_last)
  );

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign kl_clr   = (state_q == ST_CLR);
  assign mem_rd   = (state_q == ST_FETCH);
  assign mem_addr = KEY_BASE + 22'(idx_q);
  assign kl_din   = ((state_q == ST_EMIT_HI) || (state_q == ST_GAP_HI)) ? data_q[15:8] : data_q[7:0];

`ifdef JTCPS2_KEYSEQ_SUM_EN
  logic [11:0] sum_q;

  // Running byte checksum: restarted in CLR, accumulates each strobed byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state_q == ST_CLR) begin
      sum_q <= '0;
    end else if (kl_we) begin
      sum_q <= sum_q + {4'd0, kl_din};
    end
  end

  assign sum = sum_q;
`else
  assign sum = 12'd0;
`endif

endmodule

// File: tb/tb_jtcps2_keyseq.sv
// Directed testbench for jtcps2_keyseq. DUT A: KEY_BASE=22'h1000, GAP=4, memory
// acknowledging on the 4th cycle of a read. DUT B: GAP=1, memory acknowledging
// in the same cycle as the read request.
module tb_jtcps2_keyseq;

  localparam logic [21:0] BASE_A = 22'h001000;

  logic clk, rst;

  // DUT A signals
  logic        start_a, abort_a, busy_a, done_a, mem_rd_a, mem_ok_a, kl_clr_a, kl_we_a;
  logic [21:0] mem_addr_a;
  logic [15:0] mem_data_a;
  logic [7:0]  kl_din_a;
  logic [11:0] sum_a;
  logic        spur_ok;
  int          rd_cnt;

  // DUT B signals
  logic        start_b, abort_b, busy_b, done_b, mem_rd_b, mem_ok_b, kl_clr_b, kl_we_b;
  logic [21:0] mem_addr_b;
  logic [15:0] mem_data_b;
  logic [7:0]  kl_din_b;
  logic [11:0] sum_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state
  logic [7:0] bytes_a[$];
  logic       hist_b[$];
  logic       prev_we_a = 1'b0;
  int         clr_cnt_a = 0;
  int         clr_cnt_b = 0;
  bit         sum_nz    = 1'b0;

  // Key word i holds bytes 2i+1 (low) and 2i+2 (high).
  function automatic logic [15:0] word_at(input logic [21:0] addr, input logic [21:0] base);
    int o;
    o = int'(addr - base);
    if (o >= 0 && o < 10) return {8'(2 * o + 2), 8'(2 * o + 1)};
    return 16'hDEAD;
  endfunction

  assign mem_ok_a   = (mem_rd_a && rd_cnt == 3) || spur_ok;
  assign mem_data_a = word_at(mem_addr_a, BASE_A);
  assign mem_ok_b   = mem_rd_b;
  assign mem_data_b = word_at(mem_addr_b, 22'h0);

  always @(posedge clk) rd_cnt <= mem_rd_a ? rd_cnt + 1 : 0;

  jtcps2_keyseq #(.KEY_BASE(BASE_A), .GAP(4), .WORDS(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
    .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_ok(mem_ok_a), .mem_data(mem_data_a),
    .kl_clr(kl_clr_a), .kl_din(kl_din_a), .kl_we(kl_we_a), .sum(sum_a)
  );

  jtcps2_keyseq #(.KEY_BASE(22'h0), .GAP(1), .WORDS(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_ok(mem_ok_b), .mem_data(mem_data_b),
    .kl_clr(kl_clr_b), .kl_din(kl_din_b), .kl_we(kl_we_b), .sum(sum_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (kl_we_a && !prev_we_a) bytes_a.push_back(kl_din_a);
    prev_we_a = kl_we_a;
    if (kl_clr_a) clr_cnt_a++;
    if (kl_clr_b) clr_cnt_b++;
    if (busy_b) hist_b.push_back(kl_we_b);
    if (sum_a != 12'd0 || sum_b != 12'd0) sum_nz = 1'b1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Pulse start on DUT A and count busy cycles until done (bounded).
  task automatic run_a(output int busy_cycles, output bit timed_out);
    int guard;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    busy_cycles = 0;
    guard = 0;
    while (!done_a && guard < 2000) begin
      if (busy_a) busy_cycles++;
      step();
      guard++;
    end
    timed_out = !done_a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy_a, done_a, mem_rd_a, kl_clr_a, kl_we_a} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy_a, done_a, mem_rd_a, kl_clr_a, kl_we_a});
    end
    n_tests++;
    if (mem_addr_a !== BASE_A) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want %h", mem_addr_a, BASE_A);
    end
    n_tests++;
    if ({kl_din_a, sum_a} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_din_sum: got %h/%h want 00/000", kl_din_a, sum_a);
    end
    @(negedge clk);
    rst = 1'b0;
    step(2);
    n_tests++;
    if ({busy_a, done_a, busy_b, done_b} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 0000", {busy_a, done_a, busy_b, done_b});
    end
  endtask

  task automatic test_full_sequence();
    int  cyc, bad;
    bit  to;
    bytes_a.delete();
    clr_cnt_a = 0;
    run_a(cyc, to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL full_timeout: done never rose");
    end
    n_tests++;
    if (cyc !== 141) begin
      n_fail++;
      $display("FAIL full_busy_cycles: got %0d want 141", cyc);
    end
    n_tests++;
    if ({done_a, busy_a, kl_we_a, mem_rd_a} !== 4'b1000) begin
      n_fail++;
      $display("FAIL full_done_flags: got %b want 1000", {done_a, busy_a, kl_we_a, mem_rd_a});
    end
    n_tests++;
    if (bytes_a.size() !== 20) begin
      n_fail++;
      $display("FAIL full_strobe_count: got %0d want 20", bytes_a.size());
    end
    bad = 0;
    foreach (bytes_a[i]) if (bytes_a[i] !== 8'(i + 1)) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL full_byte_values: %0d bytes wrong, first=%h want 01", bad,
               (bytes_a.size() > 0) ? bytes_a[0] : 8'hxx);
    end
    n_tests++;
    if (clr_cnt_a !== 1) begin
      n_fail++;
      $display("FAIL full_clr_count: got %0d want 1", clr_cnt_a);
    end
  endtask

  task automatic test_sum();
    logic [11:0] exp_sum;
`ifdef JTCPS2_KEYSEQ_SUM_EN
    exp_sum = 12'h0D2;
`else
    exp_sum = 12'h000;
    n_tests++;
    if (sum_nz !== 1'b0) begin
      n_fail++;
      $display("FAIL sum_tied_zero: got nonzero sum during run want 000");
    end
`endif
    n_tests++;
    if (sum_a !== exp_sum) begin
      n_fail++;
      $display("FAIL sum_in_done: got %h want %h", sum_a, exp_sum);
    end
    step(5);
    n_tests++;
    if ({done_a, sum_a} !== {1'b1, exp_sum}) begin
      n_fail++;
      $display("FAIL sum_held: got done=%b sum=%h want 1/%h", done_a, sum_a, exp_sum);
    end
  endtask

  task automatic test_abort_in_done();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    n_tests++;
    if ({done_a, busy_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_in_done: got done/busy=%b want 10", {done_a, busy_a});
    end
  endtask

  task automatic test_abort_fetch5();
    int guard;
    bytes_a.delete();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n_tests++;
    if ({busy_a, done_a, kl_clr_a} !== 3'b101) begin
      n_fail++;
      $display("FAIL restart_clr: got busy/done/clr=%b want 101", {busy_a, done_a, kl_clr_a});
    end
    guard = 0;
    while (!(mem_rd_a && mem_addr_a == BASE_A + 22'd4) && guard < 500) begin
      step();
      guard++;
    end
    n_tests++;
    if (!(mem_rd_a && mem_addr_a == BASE_A + 22'd4)) begin
      n_fail++;
      $display("FAIL abort_reach_fetch5: got addr=%h rd=%b want %h/1", mem_addr_a, mem_rd_a, BASE_A + 22'd4);
    end
    n_tests++;
    if (bytes_a.size() !== 8) begin
      n_fail++;
      $display("FAIL abort_bytes_before: got %0d want 8", bytes_a.size());
    end
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    n_tests++;
    if ({mem_rd_a, busy_a, done_a, kl_we_a} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got rd/busy/done/we=%b want 0000", {mem_rd_a, busy_a, done_a, kl_we_a});
    end
    step(60);
    n_tests++;
    if ({bytes_a.size() == 8, busy_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_quiet: got strobes=%0d busy=%b want 8/0", bytes_a.size(), busy_a);
    end
  endtask

  task automatic test_start_abort_idle();
    int clr0;
    clr0 = clr_cnt_a;
    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    n_tests++;
    if ({busy_a, kl_clr_a, mem_rd_a} !== 3'b0) begin
      n_fail++;
      $display("FAIL start_abort_state: got busy/clr/rd=%b want 000", {busy_a, kl_clr_a, mem_rd_a});
    end
    spur_ok = 1'b1;
    step();
    spur_ok = 1'b0;
    step(3);
    n_tests++;
    if ({busy_a, clr_cnt_a == clr0} !== 2'b01) begin
      n_fail++;
      $display("FAIL start_abort_quiet: got busy=%b clr=%0d want 0/%0d", busy_a, clr_cnt_a, clr0);
    end
  endtask

  task automatic test_start_while_busy();
    int guard, bad;
    bytes_a.delete();
    clr_cnt_a = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(20);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    guard = 0;
    while (!kl_we_a && guard < 100) begin
      step();
      guard++;
    end
    spur_ok = 1'b1;
    step();
    spur_ok = 1'b0;
    guard = 0;
    while (!done_a && guard < 2000) begin
      step();
      guard++;
    end
    n_tests++;
    if (done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_done: got %b want 1", done_a);
    end
    bad = (bytes_a.size() == 20) ? 0 : 1;
    foreach (bytes_a[i]) if (bytes_a[i] !== 8'(i + 1)) bad++;
    n_tests++;
    if (bad !== 0 || clr_cnt_a !== 1) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got %0d strobes, %0d bad, clr=%0d want 20/0/1",
               bytes_a.size(), bad, clr_cnt_a);
    end
  endtask

  task automatic test_gap1();
    int guard, cyc, i, w, z, k, bad_w, bad_l;
    hist_b.delete();
    clr_cnt_b = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    guard = 0;
    cyc = 0;
    while (!done_b && guard < 500) begin
      if (busy_b) cyc++;
      step();
      guard++;
    end
    n_tests++;
    if (cyc !== 51 || done_b !== 1'b1) begin
      n_fail++;
      $display("FAIL gap1_length: got %0d cycles done=%b want 51/1", cyc, done_b);
    end
    i = 0;
    while (i < hist_b.size() && hist_b[i] == 1'b0) i++;
    k = 0;
    bad_w = 0;
    bad_l = 0;
    while (i < hist_b.size()) begin
      w = 0;
      while (i < hist_b.size() && hist_b[i] == 1'b1) begin w++; i++; end
      z = 0;
      while (i < hist_b.size() && hist_b[i] == 1'b0) begin z++; i++; end
      if (w != 1) bad_w++;
      if (z != (((k % 2) == 1 && k != 19) ? 2 : 1)) bad_l++;
      k++;
    end
    n_tests++;
    if (k !== 20) begin
      n_fail++;
      $display("FAIL gap1_pulses: got %0d want 20", k);
    end
    n_tests++;
    if ({bad_w, bad_l} !== {32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL gap1_shape: got %0d bad widths, %0d bad gaps want 0/0", bad_w, bad_l);
    end
  endtask

  task automatic test_rst_mid_emit_hi();
    int guard;
    bytes_a.delete();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    guard = 0;
    while (!(kl_we_a && bytes_a.size() == 4) && guard < 500) begin
      step();
      guard++;
    end
    n_tests++;
    if (!(kl_we_a && kl_din_a == 8'h04)) begin
      n_fail++;
      $display("FAIL rst_reach_emit_hi: got we=%b din=%h want 1/04", kl_we_a, kl_din_a);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy_a, done_a, mem_rd_a, kl_clr_a, kl_we_a, kl_din_a, sum_a} !== 25'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b rd=%b clr=%b we=%b din=%h sum=%h want all 0",
               busy_a, done_a, mem_rd_a, kl_clr_a, kl_we_a, kl_din_a, sum_a);
    end
    n_tests++;
    if (mem_addr_a !== BASE_A) begin
      n_fail++;
      $display("FAIL rst_mid_addr: got %h want %h", mem_addr_a, BASE_A);
    end
    step();
    rst = 1'b0;
    step(10);
    n_tests++;
    if ({busy_a, done_a, bytes_a.size() == 4} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_no_resume: got busy=%b done=%b strobes=%0d want 0/0/4",
               busy_a, done_a, bytes_a.size());
    end
  endtask

  initial begin
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    spur_ok = 1'b0;
    test_reset();
    test_full_sequence();
    test_sum();
    test_abort_in_done();
    test_abort_fetch5();
    test_start_abort_idle();
    test_start_while_busy();
    test_gap1();
    test_rst_mid_emit_hi();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
